mips_dmem_responder: RTL
========================

Name: mips_dmem_responder

Overview:
- Data-memory responder for the MIPS datapath's load/store port.
- Takes the datapath address (ALU result), store data and access controls.
- Performs byte-, halfword- or word-sized accesses against an internal word-addressed RAM with a programmable wait-state latency.
- Returns load data, sign- or zero-extended, through a req/ready handshake so the core controller can stall on memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM; valid byte addresses are 0 .. DEPTH_WORDS*4-1.
- LATENCY, 2, cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_req  input  1  access request; held high by the master until mem_ready
- mem_we  input  1  1 = store, 0 = load
- mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- mem_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- mem_addr  input  DATA_MEM_WIDTH  byte address
- mem_wdata  input  DATA_MEM_WIDTH  store data, right-justified
- mem_rdata  output  DATA_MEM_WIDTH  load data; valid only while mem_ready=1
- mem_ready  output  1  one-cycle completion pulse
- mem_err  output  1  qualifies mem_ready: access rejected (misaligned, out of range, illegal size)
- busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: mem_ready=0, mem_err=0, mem_rdata=0, busy=0, state=IDLE, latency counter=0. RAM contents are not reset.
- FSM states:
  - IDLE: when mem_req=1, register we/size/sign/addr/wdata, run the error check and go to WAIT. The acceptance cycle is T.
  - WAIT: counter counts up to LATENCY-1, then go to RESP. With LATENCY=1, go straight to RESP.
  - RESP: mem_ready=1 for exactly one cycle at cycle T+LATENCY, then return to IDLE.
- Back-to-back requests: mem_req is sampled again in IDLE only, so the earliest next acceptance is T+LATENCY+1. The master must drop mem_req, or present the next request, in the cycle after mem_ready.
- Dropping mem_req mid-transaction is ignored; the captured transaction completes, including its write.
- Input changes after acceptance are ignored; only registered fields are used.
- Error check, done at acceptance: error if any of the following:
  - mem_size=11
  - half access with addr[0]=1
  - word access with addr[1:0]!=00
  - addr >= DEPTH_WORDS*4
- On error: mem_err=1 together with mem_ready at T+LATENCY. No RAM write occurs. mem_rdata=0.
- Addressing: word index = addr[log2(DEPTH_WORDS)+1:2]. Little-endian; byte lane = addr[1:0], half lane = addr[1].
- Stores:
  - Byte-lane write enables derived from size/lane. Byte writes wdata[7:0] into the selected lane; half writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}; word writes all four lanes.
  - The write commits on the RESP-entry clock edge (end of the last WAIT cycle), so reset before that edge aborts the store with no RAM change.
- Loads:
  - The RAM word is read in the last WAIT cycle and the lane is extracted.
  - Extension: byte -> bits 31:8 = sign ? bit7 : 0; half -> bits 31:16 = sign ? bit15 : 0; word passes unchanged.
  - mem_rdata is registered, driven with ready, and returns to 0 the cycle after.
- Load/store to same address in consecutive transactions: the load returns the newly stored data (write commits before the next acceptance).
- Reset mid-operation: FSM returns to IDLE immediately; no ready pulse is produced for the aborted transaction.

Decomposition:
- Shared package mips_pkg:
  - mem_size_t enum {MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10}
  - dmem_state_t enum {DMEM_IDLE, DMEM_WAIT, DMEM_RESP}
  - DMEM_LAT_WIDTH=4
  - existing DATA_MEM_WIDTH
- Sub-module mips_dmem_lane_align, combinational:
  - store path: lane shift plus 4-bit byte enables from size/addr[1:0]
  - load path: lane extraction plus sign/zero extension
- The RAM array and FSM stay in the top module.

Test Plan:
- Word store addr=0x10 wdata=0xDEADBEEF, then word load addr=0x10, LATENCY=2 -> ready at T+2 each time, rdata=0xDEADBEEF, err=0.
- Byte store addr=0x11 wdata=0x000000AA over word 0x11223344 at 0x10 -> word reads 0x1122AA44. Byte load addr=0x11 sign=1 -> 0xFFFFFFAA; sign=0 -> 0x000000AA.
- Half load addr=0x12 from word 0x8001_7FFF, sign=1 -> 0xFFFF8001. Half load addr=0x10, sign=1 -> 0x00007FFF.
- Error cases, each giving ready+err at T+LATENCY, rdata=0, RAM unchanged:
  - word access addr=0x13
  - half access addr=0x11
  - mem_size=11
  - addr=DEPTH_WORDS*4=0x400
- rst_n asserted during WAIT of a word store to 0x20 (prior value 0x0) -> no ready pulse, busy=0, later load of 0x20 returns 0x00000000.
- mem_req held high continuously across two requests, LATENCY=1 -> acceptances at T and T+2, ready at T+1 and T+3, never two ready pulses in consecutive cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the data-memory responder.
package mips_pkg;

    localparam int DATA_MEM_WIDTH = 32;
    localparam int DMEM_LAT_WIDTH = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

endpackage

// File: rtl/mips_dmem_lane_align.sv
// Little-endian lane steering: store-side replication plus byte enables,
// load-side lane extraction with sign/zero extension.
module mips_dmem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]                i_size,
    input  logic [1:0]                i_lane,
    input  logic                      i_sign,
    input  logic [DATA_MEM_WIDTH-1:0] i_wdata,
    input  logic [DATA_MEM_WIDTH-1:0] i_rword,
    output logic [DATA_MEM_WIDTH-1:0] o_wword,
    output logic [3:0]                o_be,
    output logic [DATA_MEM_WIDTH-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        o_wword = i_wdata;
        o_be    = 4'b0000;
        o_rdata = i_rword;
        case (i_size)
            MEM_BYTE: begin
                o_wword = {4{i_wdata[7:0]}};
                o_be    = 4'b0001 << i_lane;
                o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
            end
            MEM_HALF: begin
                o_wword = {2{i_wdata[15:0]}};
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_rdata = {{16{i_sign & w_half[15]}}, w_half};
            end
            MEM_WORD: o_be = 4'b1111;
            default:  o_be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: word RAM behind a req/ready handshake with a
// fixed wait-state latency, byte/half/word accesses and error reporting.
module mips_dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [1:0]                mem_size,
    input  logic                      mem_sign,
    input  logic [DATA_MEM_WIDTH-1:0] mem_addr,
    input  logic [DATA_MEM_WIDTH-1:0] mem_wdata,
    output logic [DATA_MEM_WIDTH-1:0] mem_rdata,
    output logic                      mem_ready,
    output logic                      mem_err,
    output logic                      busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_LAT_WIDTH-1:0] LAT_LAST = DMEM_LAT_WIDTH'(LATENCY - 1);
    localparam logic [DATA_MEM_WIDTH-1:0] ADDR_LIMIT = DATA_MEM_WIDTH'(DEPTH_WORDS * 4);

    dmem_state_t                r_state;
    logic [DMEM_LAT_WIDTH-1:0]  r_cnt;
    logic                       r_we;
    logic                       r_sign;
    logic [1:0]                 r_size;
    logic [DATA_MEM_WIDTH-1:0]  r_addr;
    logic [DATA_MEM_WIDTH-1:0]  r_wdata;
    logic                       r_ready;
    logic                       r_err;
    logic [DATA_MEM_WIDTH-1:0]  r_rdata;
    logic [DATA_MEM_WIDTH-1:0]  r_mem [DEPTH_WORDS];

    logic                       w_idle;
    logic                       w_fire;
    logic                       w_we;
    logic                       w_sign;
    logic [1:0]                 w_size;
    logic [DATA_MEM_WIDTH-1:0]  w_addr;
    logic [DATA_MEM_WIDTH-1:0]  w_wdata;
    logic                       w_bad;
    logic [AW-1:0]              w_idx;
    logic [DATA_MEM_WIDTH-1:0]  w_rword;
    logic [DATA_MEM_WIDTH-1:0]  w_wword;
    logic [DATA_MEM_WIDTH-1:0]  w_load;
    logic [3:0]                 w_be;
    logic                       w_wr_en;

    assign w_idle = (r_state == DMEM_IDLE);

    // With LATENCY=1 there is no WAIT cycle, so the access executes in the
    // acceptance cycle straight from the inputs; otherwise from captured fields.
    assign w_fire = (LATENCY == 1) ? (w_idle & mem_req)
                                   : ((r_state == DMEM_WAIT) && (r_cnt == LAT_LAST));

    assign w_we    = w_idle ? mem_we    : r_we;
    assign w_sign  = w_idle ? mem_sign  : r_sign;
    assign w_size  = w_idle ? mem_size  : r_size;
    assign w_addr  = w_idle ? mem_addr  : r_addr;
    assign w_wdata = w_idle ? mem_wdata : r_wdata;

    assign w_bad = (w_size == 2'b11)
                 | ((w_size == MEM_HALF) & w_addr[0])
                 | ((w_size == MEM_WORD) & (w_addr[1:0] != 2'b00))
                 | (w_addr >= ADDR_LIMIT);

    assign w_idx   = w_addr[AW+1:2];
    assign w_rword = r_mem[w_idx];
    assign w_wr_en = rst_n & w_fire & w_we & ~w_bad;

    mips_dmem_lane_align u_align (
        .i_size  (w_size),
        .i_lane  (w_addr[1:0]),
        .i_sign  (w_sign),
        .i_wdata (w_wdata),
        .i_rword (w_rword),
        .o_wword (w_wword),
        .o_be    (w_be),
        .o_rdata (w_load)
    );

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DMEM_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_sign  <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_fire;
            r_err   <= w_fire & w_bad;
            r_rdata <= (w_fire & ~w_bad & ~w_we) ? w_load : '0;
            case (r_state)
                DMEM_IDLE: begin
                    if (mem_req) begin
                        r_we    <= mem_we;
                        r_sign  <= mem_sign;
                        r_size  <= mem_size;
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_cnt   <= DMEM_LAT_WIDTH'(1);
                        r_state <= (LATENCY == 1) ? DMEM_RESP : DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (r_cnt == LAT_LAST) r_state <= DMEM_RESP;
                    else                   r_cnt   <= r_cnt + 1'b1;
                end
                DMEM_RESP: r_state <= DMEM_IDLE;
                default:   r_state <= DMEM_IDLE;
            endcase
        end
    end

    assign mem_ready = r_ready;
    assign mem_err   = r_err;
    assign mem_rdata = r_rdata;
    assign busy      = ~w_idle;

endmodule
